// File: rtl/snn_readout_pkg.sv
// Shared types and sizing helpers for the SNN output-layer readout sequencer.
package snn_readout_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // One window covers every row at the largest possible weight count.
  function automatic int unsigned default_max_ticks(input int unsigned width,
                                                    input int unsigned height);
    return height * ((32'd1 << width) - 32'd1);
  endfunction

  function automatic int unsigned class_w(input int unsigned num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/snn_winner_select.sv
// Lowest-index priority encoder over the neuron fire flags, plus any/tie flags.
module snn_winner_select
  import snn_readout_pkg::*;
#(
  parameter int unsigned NUM_OUT = 4,
  localparam int unsigned CLS_W  = class_w(NUM_OUT)
) (
  input  logic [NUM_OUT-1:0] i_fire,
  output logic [CLS_W-1:0]   o_idx,
  output logic               o_any,
  output logic               o_tie
);

  logic [NUM_OUT-1:0] w_fire_m1;

  assign w_fire_m1 = i_fire - {{(NUM_OUT-1){1'b0}}, 1'b1};

  always_comb begin
    o_idx = '0;
    // Descending scan so the lowest set index is written last and wins.
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (i_fire[i]) o_idx = CLS_W'(i);
    end
  end

  assign o_any = |i_fire;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_tie = |(i_fire & w_fire_m1);

endmodule

// File: rtl/snn_readout_ctrl.sv
// Readout sequencer: clears the output neurons, gates one classification window,
// and hands back the first-to-fire class index over a valid/ready handshake.
module snn_readout_ctrl
  import snn_readout_pkg::*;
#(
  parameter int unsigned NUM_OUT   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 7,
  parameter int unsigned MAX_TICKS = default_max_ticks(WIDTH, HEIGHT),
  localparam int unsigned CLS_W    = class_w(NUM_OUT),
  localparam int unsigned CNT_W    = $clog2(MAX_TICKS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  input  logic [NUM_OUT-1:0] i_neuron_fire,
  output logic               o_neuron_clr_n,
  output logic               o_neuron_en,
  output logic [CLS_W-1:0]   o_result_class,
  output logic               o_result_timeout,
  output logic               o_result_tie,
  output logic               o_result_valid,
  input  logic               i_result_ready
);

  state_t             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [CLS_W-1:0]   r_class, w_class_d;
  logic               r_timeout, w_timeout_d;
  logic               r_tie, w_tie_d;
  logic               r_busy, r_clr_n, r_en, r_valid;

  logic [CLS_W-1:0]   w_win_idx;
  logic               w_win_any, w_win_tie;
  logic               w_last_tick;

  snn_winner_select #(
    .NUM_OUT (NUM_OUT)
  ) u_winner (
    .i_fire (i_neuron_fire),
    .o_idx  (w_win_idx),
    .o_any  (w_win_any),
    .o_tie  (w_win_tie)
  );

  assign w_last_tick = (r_cnt == CNT_W'(MAX_TICKS - 1));

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_class_d   = r_class;
    w_timeout_d = r_timeout;
    w_tie_d     = r_tie;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_cnt_d   = '0;
        w_state_d = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_d = r_cnt + CNT_W'(1);
        // A fire on the last tick still beats the timeout.
        if (w_win_any) begin
          w_class_d   = w_win_idx;
          w_tie_d     = w_win_tie;
          w_timeout_d = 1'b0;
          w_state_d   = ST_DONE;
        end else if (w_last_tick) begin
          w_class_d   = '0;
          w_tie_d     = 1'b0;
          w_timeout_d = 1'b1;
          w_state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_result_ready) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_class   <= '0;
      r_timeout <= 1'b0;
      r_tie     <= 1'b0;
      r_busy    <= 1'b0;
      r_clr_n   <= 1'b0;
      r_en      <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_class   <= w_class_d;
      r_timeout <= w_timeout_d;
      r_tie     <= w_tie_d;
      r_busy    <= (w_state_d != ST_IDLE);
      r_clr_n   <= (w_state_d != ST_CLEAR);
      r_en      <= (w_state_d == ST_RUN);
      r_valid   <= (w_state_d == ST_DONE);
    end
  end

  assign o_busy           = r_busy;
  assign o_neuron_clr_n   = r_clr_n;
  assign o_neuron_en      = r_en;
  assign o_result_class   = r_class;
  assign o_result_timeout = r_timeout;
  assign o_result_tie     = r_tie;
  assign o_result_valid   = r_valid;

endmodule

// File: tb/tb_snn_readout_ctrl.sv
// Bench for snn_readout_ctrl: directed plan cases plus randomized images against a
// transaction-level model of the first-to-fire / timeout rules.
module tb_snn_readout_ctrl;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned MT      = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] fire  = 4'b0000;
  logic       busy, clr_n, en, tmo, tie, valid;
  logic [1:0] cls;

  int n_checks = 0;
  int n_errors = 0;

  snn_readout_ctrl #(
    .NUM_OUT   (NUM_OUT),
    .WIDTH     (8),
    .HEIGHT    (7),
    .MAX_TICKS (MT)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .o_busy           (busy),
    .i_neuron_fire    (fire),
    .o_neuron_clr_n   (clr_n),
    .o_neuron_en      (en),
    .o_result_class   (cls),
    .o_result_timeout (tmo),
    .o_result_tie     (tie),
    .o_result_valid   (valid),
    .i_result_ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_clr_n"}, 32'(clr_n), 32'd0);
    check({tag, "_en"},    32'(en),    32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_class"}, 32'(cls),   32'd0);
    check({tag, "_tmo"},   32'(tmo),   32'd0);
    check({tag, "_tie"},   32'(tie),   32'd0);
  endtask

  // Leaves the bench #1 into the first RUN cycle (tick counter 0).
  task automatic do_start(input bit stale);
    start = 1'b1;
    if (stale) fire = 4'b0001;
    tick();
    start = 1'b0;
    check("clear_clr_n", 32'(clr_n), 32'd0);
    check("clear_en",    32'(en),    32'd0);
    check("clear_busy",  32'(busy),  32'd1);
    tick();
    fire = 4'b0000;
    check("run_clr_n", 32'(clr_n), 32'd1);
    check("run_en",    32'(en),    32'd1);
    check("run_valid", 32'(valid), 32'd0);
  endtask

  // ft >= MT means no neuron fires within the window.
  task automatic run_image(input int ft, input logic [3:0] pat, input bit stale, input int hold);
    int exp_cls;
    bit exp_tie;
    bit exp_tmo;
    int last;
    if (ft < int'(MT)) begin
      exp_cls = lowest_set(pat);
      exp_tie = ($countones(pat) > 1);
      exp_tmo = 1'b0;
      last    = ft;
    end else begin
      exp_cls = 0;
      exp_tie = 1'b0;
      exp_tmo = 1'b1;
      last    = MT - 1;
    end
    do_start(stale);
    for (int c = 0; c <= last; c++) begin
      if (c == ft) fire = pat;
      tick();
      if (c < last) begin
        check("run_no_early_valid", 32'(valid), 32'd0);
        check("run_en_high",        32'(en),    32'd1);
      end
    end
    check("done_valid", 32'(valid),   32'd1);
    check("done_en",    32'(en),      32'd0);
    check("done_busy",  32'(busy),    32'd1);
    check("done_class", 32'(cls),     32'(exp_cls));
    check("done_tie",   32'(tie),     32'(exp_tie));
    check("done_tmo",   32'(tmo),     32'(exp_tmo));
    for (int h = 0; h < hold; h++) begin
      fire  = 4'($urandom);
      start = 1'($urandom);
      tick();
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_class", 32'(cls),   32'(exp_cls));
      check("hold_tie",   32'(tie),   32'(exp_tie));
      check("hold_tmo",   32'(tmo),   32'(exp_tmo));
      check("hold_en",    32'(en),    32'd0);
    end
    fire  = 4'b0000;
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_busy",  32'(busy),  32'd0);
    check("idle_en",    32'(en),    32'd0);
    check("idle_clr_n", 32'(clr_n), 32'd1);
  endtask

  initial begin
    #2;
    check_reset_vals("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_clr_n", 32'(clr_n), 32'd1);
    check("post_rst_busy",  32'(busy),  32'd0);

    run_image(10, 4'b0100, 1'b0, 50);
    run_image(10, 4'b1010, 1'b0, 0);
    run_image(MT, 4'b0000, 1'b0, 0);
    run_image(MT - 1, 4'b0001, 1'b0, 0);
    run_image(3, 4'b1000, 1'b1, 2);
    run_image(MT + 2, 4'b0000, 1'b1, 0);

    // Abort mid-window with an asynchronous reset.
    do_start(1'b0);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_clr_n", 32'(clr_n), 32'd1);
    for (int i = 0; i < int'(MT) + 3; i++) begin
      tick();
      check("rel_no_valid", 32'(valid), 32'd0);
    end
    run_image(7, 4'b0110, 1'b0, 1);

    for (int n = 0; n < 12; n++) begin
      run_image(int'($urandom_range(0, MT + 3)), 4'($urandom_range(1, 15)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snn_readout_ctrl.md
# snn_readout_ctrl

Sequencer for the SNN perceptron output layer: clears an array of NUM_OUT integrate-to-threshold output neurons, gates the pixel stream into them for one classification window, detects the first neuron to reach threshold, and returns the winning class index over a valid/ready handshake. It sits between the pixel/spike source and the output-neuron array; the neurons themselves stay unchanged and are driven only through their enable and circuit-reset inputs.

## Interface
- NUM_OUT, 4, number of output neurons / classes (≥2)
- WIDTH, 8, neuron weight width, matches the neuron array
- HEIGHT, 7, input rows per image, matches the neuron array
- MAX_TICKS, HEIGHT*(2**WIDTH-1), window length in clk cycles before timeout (≥1)

- clk  in  1  single system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request to classify one image, sampled in IDLE only
- busy  out  1  high in every state except IDLE
- neuron_fire  in  NUM_OUT  threshold-reached flags from the neuron array (level, sticky until cleared)
- neuron_clr_n  out  1  active-low circuit reset to all neurons
- neuron_en  out  1  pixel gate into neurons; high only in RUN
- result_class  out  $clog2(NUM_OUT)  winning index
- result_timeout  out  1  window expired with no neuron firing
- result_tie  out  1  more than one neuron fired in the deciding cycle
- result_valid  out  1  result fields valid
- result_ready  in  1  consumer accepts result

## Operation
- States: IDLE, CLEAR, RUN, DONE (encoding in package).
- IDLE: outputs inactive; start=1 → CLEAR.
- CLEAR: exactly one cycle; neuron_clr_n=0, tick counter ← 0 → RUN.
- RUN: neuron_en=1; tick counter +1 per cycle. Each cycle evaluate neuron_fire:
  - any bit set → latch result_class = lowest set index, result_tie = (popcount>1), result_timeout=0 → DONE.
  - none set and counter == MAX_TICKS-1 → result_class=0, result_tie=0, result_timeout=1 → DONE.
  - fire and last tick in same cycle → fire wins (timeout=0).
- DONE: result_valid=1, result fields stable; neuron_en=0 (neurons frozen). result_ready=1 → IDLE. start ignored in DONE and RUN.
- neuron_fire in CLEAR is ignored (stale from previous image).
- Counter width $clog2(MAX_TICKS+1); never wraps, saturates by state exit.

## Timing
- Reset (async, any state): state=IDLE, busy=0, neuron_clr_n=0 while rst low then 1, neuron_en=0, result_valid=0, result_class=0, result_timeout=0, result_tie=0, counter=0. Reset mid-RUN aborts; no result emitted.
- start seen at edge N → CLEAR during N..N+1 → RUN from edge N+1; first gated pixel in cycle after CLEAR.
- neuron_fire sampled at edge E in RUN → result_valid high from E (registered), i.e. one cycle after the firing cycle.
- Timeout: result_valid rises exactly MAX_TICKS cycles after entering RUN.
- result_valid & result_ready at edge → IDLE next cycle; back-to-back image: start may be high in that IDLE cycle, minimum period = MAX_TICKS+3 cycles for timeout case.
- result_valid held indefinitely while result_ready=0; fields must not change.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package snn_readout_pkg: state enum type, default MAX_TICKS function of WIDTH/HEIGHT, class-index width helper.
- Sub-module snn_winner_select: combinational lowest-index priority encoder plus any/tie flags over NUM_OUT bits.
- Top contains FSM, tick counter, result registers.

## Test plan
- Single winner: NUM_OUT=4, start, assert neuron_fire=4'b0100 at RUN tick 10 → result_valid one cycle later, class=2, tie=0, timeout=0; neuron_en low in DONE.
- Tie: neuron_fire=4'b1010 same cycle → class=1, tie=1.
- Timeout: MAX_TICKS=20, no fire → result_valid exactly 20 cycles after RUN entry, timeout=1, class=0; fire at tick 19 instead → timeout=0.
- Backpressure: hold result_ready=0 for 50 cycles, toggle neuron_fire and start → fields stable, state stays DONE; ready=1 → IDLE next cycle.
- Stale fire: neuron_fire=4'b0001 high entering CLEAR, dropped at RUN start → ignored in CLEAR, neuron_clr_n low exactly one cycle, no premature result.
- Reset mid-RUN at tick 5 → all outputs to reset values immediately (async), no result_valid after release, next start works normally.
